cmp_query_ctrl: RTL and testbench
=================================

# cmp_query_ctrl

Requester-side controller for the ALU compare unit. It accepts a compare query with a valid/ready handshake, drives the compare unit's operand, enable and function inputs one test at a time (EQ, GT, LT), and waits for each registered result. It decodes each returned code and presents a single combined relation response downstream with a valid/ready handshake. It sits between the instruction/control path and the compare unit, and guards against a missing result with a timeout.

## Interface
Parameters:
- A_WIDTH, 5, operand A width
- B_WIDTH, 5, operand B width
- CMP_WIDTH, 5, compare-unit result width (≥2)
- TIMEOUT, 4, max WAIT cycles per test (≥2)

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  query present
- req_ready  out  1  controller can accept
- req_a  in  A_WIDTH  operand A
- req_b  in  B_WIDTH  operand B
- req_mask  in  3  tests to run: bit0 EQ, bit1 GT, bit2 LT
- cmp_A  out  A_WIDTH  operand A to compare unit (latched)
- cmp_B  out  B_WIDTH  operand B to compare unit (latched)
- cmp_en  out  1  compare-unit enable
- cmp_func  out  2  compare-unit function: 01 EQ, 10 GT, 11 LT, 00 idle
- CMP_OUT  in  CMP_WIDTH  registered compare result
- CMP_Flag  in  1  compare result valid
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts
- rsp_eq, rsp_gt, rsp_lt  out  1 each  test results (0 if the test was not run)
- rsp_err  out  1  timeout or illegal result code

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1 (0 while RST high). On req_valid&req_ready:
  - latch req_a/req_b into cmp_A/cmp_B;
  - latch req_mask into the pending set;
  - clear the result bits and err.
  - Go to ISSUE if mask≠0, else to DONE with all result bits 0.
- ISSUE (one cycle):
  - cmp_en=1; cmp_func=code of the lowest pending bit (EQ before GT before LT).
  - Go to WAIT and clear the timeout counter. CMP_Flag is ignored in this state.
- WAIT: cmp_en=0, cmp_func=00. On CMP_Flag=1, decode CMP_OUT:
  - CMP_OUT equals the issued code (1/2/3): set the matching result bit.
  - CMP_OUT = 0: leave the result bit 0.
  - Any other value: set err; the result bit stays 0.
  - Clear the pending bit. Go to ISSUE if more tests are pending, else DONE.
- WAIT timeout:
  - If CMP_Flag=0 for TIMEOUT consecutive WAIT cycles: set err, drop the remaining pending tests, go to DONE.
  - Results already collected are kept.
- DONE: rsp_valid=1. rsp_eq/gt/lt/err are held stable until rsp_valid&rsp_ready, then go to IDLE.
- cmp_A/cmp_B hold the last latched operands between queries.

## Timing
- Reset (RST high at an edge) values: state IDLE, cmp_en=0, cmp_func=00, cmp_A=cmp_B=0, rsp_valid=0, all rsp_* =0, pending=0, counter=0.
- Reset mid-operation: the query is abandoned at the next edge. No response is produced. cmp_en is low from the following cycle.
- Latency, unit attached directly (result one cycle after issue):
  - Each test costs 2 cycles (ISSUE + one WAIT).
  - Accept at edge 0 with mask=111: ISSUE cycles 1/3/5, WAIT cycles 2/4/6, rsp_valid high from cycle 7.
  - Accept at edge 0 with mask=000: rsp_valid high in cycle 1.
- Timeout path: WAIT lasts exactly TIMEOUT cycles, then DONE.
- Handshake rules:
  - req_ready is combinational from state. rsp_valid and the rsp fields are registered.
  - rsp_valid never drops without rsp_ready.
  - A response accepted at edge n gives req_ready=1 in cycle n+1. There is no same-cycle accept of a new query while in DONE.
- A CMP_Flag arriving in ISSUE, IDLE or DONE is ignored and is not counted as a result.

## Test plan
- Reset: hold RST 2 cycles with req_valid=1 -> no accept. After release: req_ready=1, rsp_valid=0, cmp_en=0, all rsp_*=0.
- Full query, model attached: A=9, B=4, mask=111 -> cmp_func sequence 01,10,11 in cycles 1/3/5. rsp_valid in cycle 7 with eq=0, gt=1, lt=0, err=0. Repeat with A=B=7 -> eq=1, gt=0, lt=0.
- Partial and empty masks:
  - mask=100, A=2, B=6 -> a single ISSUE with func 11. rsp_valid in cycle 3 with lt=1, others 0.
  - mask=000 -> rsp_valid in cycle 1 with all zeros, and cmp_en never asserted.
- Timeout: the model withholds CMP_Flag for the GT test, TIMEOUT=4, mask=111, A=B=3 -> eq=1, err=1, gt=lt=0, and the LT test is never issued.
- Illegal code: the model returns CMP_OUT=5 with the flag for EQ -> err=1, eq=0. The remaining tests still run normally.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles -> rsp fields stable and req_ready=0 throughout. Assert RST while in WAIT -> no response, IDLE and req_ready=1 after release.

Source files
------------

// File: rtl/cmp_query_ctrl.sv
// Requester-side sequencer for the ALU compare unit: issues EQ/GT/LT tests one at a
// time, collects the registered results and returns one combined relation response.
module cmp_query_ctrl #(
  parameter int A_WIDTH   = 5,
  parameter int B_WIDTH   = 5,
  parameter int CMP_WIDTH = 5,
  parameter int TIMEOUT   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [A_WIDTH-1:0]   req_a,
  input  logic [B_WIDTH-1:0]   req_b,
  input  logic [2:0]           req_mask,
  output logic [A_WIDTH-1:0]   cmp_A,
  output logic [B_WIDTH-1:0]   cmp_B,
  output logic                 cmp_en,
  output logic [1:0]           cmp_func,
  input  logic [CMP_WIDTH-1:0] CMP_OUT,
  input  logic                 CMP_Flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_eq,
  output logic                 rsp_gt,
  output logic                 rsp_lt,
  output logic                 rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]         r_state;
  logic [2:0]         r_pending;
  logic [CW-1:0]      r_cnt;
  logic [A_WIDTH-1:0] r_cmp_a;
  logic [B_WIDTH-1:0] r_cmp_b;
  logic               r_eq;
  logic               r_gt;
  logic               r_lt;
  logic               r_err;

  logic [2:0]         w_low;
  logic [2:0]         w_rest;
  logic [1:0]         w_code;
  logic               w_hit;
  logic               w_zero;

  // The test in flight is always the lowest pending bit; it stays set until WAIT retires it.
  assign w_low  = r_pending & (~r_pending + 3'd1);
  assign w_rest = r_pending & ~w_low;

  always_comb begin
    w_code = 2'b00;
    if (r_pending[0])      w_code = 2'b01;
    else if (r_pending[1]) w_code = 2'b10;
    else if (r_pending[2]) w_code = 2'b11;
  end

  assign w_hit  = (CMP_OUT == CMP_WIDTH'(w_code));
  assign w_zero = (CMP_OUT == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_cnt     <= '0;
      r_cmp_a   <= '0;
      r_cmp_b   <= '0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cmp_a   <= req_a;
            r_cmp_b   <= req_b;
            r_pending <= req_mask;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= (req_mask != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (CMP_Flag) begin
            if (w_hit) begin
              r_eq <= r_eq | w_low[0];
              r_gt <= r_gt | w_low[1];
              r_lt <= r_lt | w_low[2];
            end else if (!w_zero) begin
              r_err <= 1'b1;
            end
            r_pending <= w_rest;
            r_state   <= (w_rest != '0) ? S_ISSUE : S_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err     <= 1'b1;
            r_pending <= '0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE) && !RST;
  assign cmp_A     = r_cmp_a;
  assign cmp_B     = r_cmp_b;
  assign cmp_en    = (r_state == S_ISSUE);
  assign cmp_func  = (r_state == S_ISSUE) ? w_code : 2'b00;
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_eq    = r_eq;
  assign rsp_gt    = r_gt;
  assign rsp_lt    = r_lt;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_cmp_query_ctrl.sv
// Bench for cmp_query_ctrl: directed queries against a one-cycle compare-unit model,
// responses checked by a scoreboard monitor.
module tb_cmp_query_ctrl;

  localparam int AW = 5;
  localparam int BW = 5;
  localparam int CW = 5;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_a = '0;
  logic [BW-1:0] req_b = '0;
  logic [2:0]    req_mask = '0;
  logic [AW-1:0] cmp_A;
  logic [BW-1:0] cmp_B;
  logic          cmp_en;
  logic [1:0]    cmp_func;
  logic [CW-1:0] CMP_OUT = '0;
  logic          CMP_Flag = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_eq, rsp_gt, rsp_lt, rsp_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  // Compare-unit model knobs: withhold the flag for one function, or corrupt one result.
  logic [1:0]    withhold_func = 2'b00;
  logic [1:0]    bad_func      = 2'b00;
  logic [CW-1:0] bad_val       = '0;

  cmp_query_ctrl #(.A_WIDTH(AW), .B_WIDTH(BW), .CMP_WIDTH(CW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mask(req_mask),
    .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_en(cmp_en), .cmp_func(cmp_func),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    CMP_Flag <= cmp_en && (cmp_func != withhold_func);
    if (cmp_en && cmp_func == bad_func && bad_func != 2'b00)
      CMP_OUT <= bad_val;
    else if (cmp_en) begin
      case (cmp_func)
        2'b01:   CMP_OUT <= (cmp_A == cmp_B) ? CW'(1) : '0;
        2'b10:   CMP_OUT <= (cmp_A >  cmp_B) ? CW'(2) : '0;
        2'b11:   CMP_OUT <= (cmp_A <  cmp_B) ? CW'(3) : '0;
        default: CMP_OUT <= '0;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Scoreboard monitor: one pop per accepted response.
  always @(negedge CLK) begin
    if (!RST && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else chk("rsp_fields", int'({rsp_eq, rsp_gt, rsp_lt, rsp_err}), int'(exp_q.pop_front()));
    end
  end

  // Issues one query; observes cycles 1..lat after the accept edge.
  task automatic query(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [2:0] mask,
                       input int lat, input logic [5:0] exp_seq, input logic [3:0] exp_rsp,
                       input bit finish);
    logic [5:0] seq;
    int first_v;
    seq = '0;
    first_v = 0;
    @(posedge CLK); #1;
    req_a = a; req_b = b; req_mask = mask; req_valid = 1'b1;
    exp_q.push_back(exp_rsp);
    @(negedge CLK);
    chk("req_ready_idle", int'(req_ready), 1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge CLK);
      if (cmp_en) seq = {seq[3:0], cmp_func};
      if (rsp_valid && first_v == 0) first_v = c;
    end
    chk("issue_seq", int'(seq), int'(exp_seq));
    chk("rsp_valid_cycle", first_v, lat);
    chk("cmp_A_latched", int'(cmp_A), int'(a));
    chk("cmp_B_latched", int'(cmp_B), int'(b));
    if (finish) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("ready_after_accept", int'(req_ready), 1);
      chk("valid_after_accept", int'(rsp_valid), 0);
    end
  endtask

  initial begin
    // Reset held with a pending request: nothing may be accepted.
    req_valid = 1'b1; req_a = 5'd11; req_b = 5'd12; req_mask = 3'b111;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("req_ready_in_reset", int'(req_ready), 0);
    end
    @(negedge CLK);
    RST = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_cmp_en", int'(cmp_en), 0);
    chk("rst_cmp_func", int'(cmp_func), 0);
    chk("rst_rsp_fields", int'({rsp_eq, rsp_gt, rsp_lt, rsp_err}), 0);
    chk("rst_cmp_A", int'(cmp_A), 0);

    query(5'd9, 5'd4, 3'b111, 7, 6'b01_10_11, 4'b0100, 1'b1);
    query(5'd7, 5'd7, 3'b111, 7, 6'b01_10_11, 4'b1000, 1'b1);
    query(5'd2, 5'd6, 3'b100, 3, 6'b00_00_11, 4'b0010, 1'b1);
    chk("cmp_A_hold_idle", int'(cmp_A), 2);
    query(5'd1, 5'd3, 3'b000, 1, 6'b00_00_00, 4'b0000, 1'b1);

    withhold_func = 2'b10;
    query(5'd3, 5'd3, 3'b111, 8, 6'b00_01_10, 4'b1001, 1'b1);
    withhold_func = 2'b00;

    bad_func = 2'b01; bad_val = 5'd5;
    query(5'd9, 5'd4, 3'b111, 7, 6'b01_10_11, 4'b0101, 1'b1);
    bad_func = 2'b00;

    // Backpressure: fields stable and no new accept while rsp_ready is low.
    @(posedge CLK); #1 rsp_ready = 1'b0;
    query(5'd2, 5'd6, 3'b111, 7, 6'b01_10_11, 4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_req_ready", int'(req_ready), 0);
      chk("bp_fields", int'({rsp_eq, rsp_gt, rsp_lt, rsp_err}), 4'b0010);
    end
    @(posedge CLK); #1 rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("bp_ready_after", int'(req_ready), 1);

    // Reset while waiting on the first result: query abandoned, no response.
    @(posedge CLK); #1;
    req_a = 5'd9; req_b = 5'd4; req_mask = 3'b111; req_valid = 1'b1;
    @(posedge CLK); #1 req_valid = 1'b0;
    @(negedge CLK);
    chk("mid_issue_en", int'(cmp_en), 1);
    @(negedge CLK);
    chk("mid_wait_en", int'(cmp_en), 0);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_cmp_en", int'(cmp_en), 0);
    chk("mid_rst_valid", int'(rsp_valid), 0);
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("post_rst_ready", int'(req_ready), 1);
      chk("post_rst_en", int'(cmp_en), 0);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
